// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants, key codes and frame FSM encoding for the PS/2 keyboard receiver.
// Also holds the small parity and prefix helpers used by the receiver.
package ps2_pkg;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // Keys the game FSM reacts to
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_J     = 8'h3B;
  localparam logic [7:0] KEY_L     = 8'h4B;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  function automatic logic is_prefix(input logic [7:0] code);
    return (code == CODE_EXT) || (code == CODE_BRK);
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Bundle of PS/2 pins and decoded key outputs between the board, the receiver and the game FSM.
interface ps2_keyboard_rx_if;

  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] tasta;
  logic       done;
  logic       extended;
  logic       frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output tasta,
    output done,
    output extended,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  tasta,
    input  done,
    input  extended,
    input  frame_err
  );

endinterface

// File: rtl/ps2_keyboard_rx_frame.sv
// PS/2 line conditioning and 11-bit frame deframer with parity check and inter-bit timeout.
// byte_valid and err are single-cycle combinational pulses on the stop-bit / error cycle.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);

  logic             clk_meta, clk_sync, data_meta, data_sync;
  logic             clk_filt;
  logic [FLT_W-1:0] flt_cnt;
  logic             flt_flip, bit_event;

  frame_state_t     state, state_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic             par_bit, par_nxt;
  logic [TO_W-1:0]  to_cnt, to_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample
  assign flt_flip  = (clk_sync != clk_filt) && (flt_cnt == FLT_MAX);
  assign bit_event = flt_flip && !clk_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_sync == clk_filt) begin
      flt_cnt  <= '0;
    end else if (flt_flip) begin
      clk_filt <= clk_sync;
      flt_cnt  <= '0;
    end else begin
      flt_cnt  <= flt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      par_bit   <= par_nxt;
      to_cnt    <= to_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    par_nxt     = par_bit;
    to_nxt      = '0;
    byte_valid  = 1'b0;
    err         = 1'b0;

    // A stalled partial frame is abandoned once the line has been quiet too long
    if (state != ST_IDLE && !bit_event) begin
      if (to_cnt == TO_MAX) begin
        state_nxt = ST_IDLE;
        err       = 1'b1;
      end else begin
        to_nxt    = to_cnt + 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (bit_event) begin
          if (!data_sync) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end else begin
            err         = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (bit_event) begin
          shift_nxt = {data_sync, shift_reg[7:1]};
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
          else bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      ST_PARITY: begin
        if (bit_event) begin
          par_nxt   = data_sync;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_event) begin
          state_nxt = ST_IDLE;
          if (data_sync && parity_ok(shift_reg, par_bit)) byte_valid = 1'b1;
          else err = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rx_byte = shift_reg;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes bytes, drops break sequences, flags E0 codes and
// presents each make code on tasta with a long done hold for the game FSM.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DONE_HOLD      = 1024
) (
  input  logic              clock,
  input  logic              reset,
  ps2_keyboard_rx_if.master bus
);

  localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DONE_HOLD - 1);

  logic [7:0]        rx_byte;
  logic              byte_valid, err;
  logic              make_valid;

  logic [7:0]        tasta_reg;
  logic              extended_reg, frame_err_reg, done_reg;
  logic              ext_pending, brk_pending;
  logic              restart;
  logic [HOLD_W-1:0] hold_cnt;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .err        (err)
  );

  assign make_valid = byte_valid && !is_prefix(rx_byte) && !brk_pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      tasta_reg     <= 8'h00;
      extended_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      ext_pending   <= 1'b0;
      brk_pending   <= 1'b0;
    end else begin
      frame_err_reg <= err;
      if (err) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == CODE_EXT) begin
          ext_pending <= 1'b1;
        end else if (rx_byte == CODE_BRK) begin
          brk_pending <= 1'b1;
        end else if (brk_pending) begin
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
        end else begin
          tasta_reg    <= rx_byte;
          extended_reg <= ext_pending;
          ext_pending  <= 1'b0;
        end
      end
    end
  end

  // A key arriving during a hold drops done for one cycle so the consumer sees a new edge
  always_ff @(posedge clock) begin
    if (reset) begin
      done_reg <= 1'b0;
      restart  <= 1'b0;
      hold_cnt <= '0;
    end else if (make_valid) begin
      if (done_reg || restart) begin
        done_reg <= 1'b0;
        restart  <= 1'b1;
      end else begin
        done_reg <= 1'b1;
        hold_cnt <= HOLD_LOAD;
      end
    end else if (restart) begin
      restart  <= 1'b0;
      done_reg <= 1'b1;
      hold_cnt <= HOLD_LOAD;
    end else if (done_reg) begin
      if (hold_cnt == '0) done_reg <= 1'b0;
      else hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign bus.tasta     = tasta_reg;
  assign bus.done      = done_reg;
  assign bus.extended  = extended_reg;
  assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: serial PS/2 frames in, key code / done / error behaviour checked.
module tb_ps2_keyboard_rx;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  ps2_keyboard_rx_if bus ();

  ps2_keyboard_rx #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (50000),
    .DONE_HOLD      (1024)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   vectors       = 0;
  int   miscompares   = 0;
  int   err_count     = 0;
  int   rises         = 0;
  int   high_run      = 0;
  int   last_high_len = 0;
  int   low_run       = 0;
  int   last_low_len  = 0;
  logic done_prev     = 1'b0;

  // Observe done edges and frame_err cycles independently of the directed steps
  always @(negedge clock) begin
    if (bus.frame_err === 1'b1) err_count++;
    if (bus.done === 1'b1) begin
      if (!done_prev) begin
        rises++;
        last_low_len = low_run;
        high_run     = 0;
      end
      high_run++;
      done_prev = 1'b1;
    end else begin
      if (done_prev) begin
        last_high_len = high_run;
        low_run       = 1;
      end else begin
        low_run++;
      end
      done_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    repeat (20) @(negedge clock);
    bus.ps2_clk = 1'b0;
    repeat (20) @(negedge clock);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    logic [7:0] v;
    v = b;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(~(^v) ^ par_flip);
    send_bit(stop);
    bus.ps2_data = 1'b1;
    repeat (30) @(negedge clock);
  endtask

  task automatic wait_done_low(input string tag);
    for (int i = 0; i < 1200 && bus.done === 1'b1; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    check(tag, 32'(bus.done), 32'h0);
  endtask

  initial begin
    int waited;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset        = 1'b1;
    repeat (5) @(negedge clock);
    check("rst_tasta",     32'(bus.tasta),     32'h00);
    check("rst_done",      32'(bus.done),      32'h0);
    check("rst_extended",  32'(bus.extended),  32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    $display("[TB] plain make code 1C");
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t1_tasta",    32'(bus.tasta),    32'h1C);
    check("t1_done",     32'(bus.done),     32'h1);
    check("t1_extended", 32'(bus.extended), 32'h0);
    check("t1_errs",     32'(err_count),    32'd0);
    wait_done_low("t1_done_fall");
    check("t1_hold_len", 32'(last_high_len), 32'd1024);
    check("t1_rises",    32'(rises),         32'd1);

    $display("[TB] break sequence F0 1C then 29");
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("brk_done",  32'(bus.done),  32'h0);
    check("brk_rises", 32'(rises),     32'd1);
    send_frame(8'h29, 1'b0, 1'b1);
    check("brk_next_tasta", 32'(bus.tasta), 32'h29);
    check("brk_next_done",  32'(bus.done),  32'h1);
    check("brk_next_rises", 32'(rises),     32'd2);

    $display("[TB] extended E0 75 then plain 23");
    send_frame(8'hE0, 1'b0, 1'b1);
    check("ext_prefix_tasta", 32'(bus.tasta), 32'h29);
    send_frame(8'h75, 1'b0, 1'b1);
    check("ext_tasta",    32'(bus.tasta),    32'h75);
    check("ext_extended", 32'(bus.extended), 32'h1);
    send_frame(8'h23, 1'b0, 1'b1);
    check("ext_clr_tasta",    32'(bus.tasta),    32'h23);
    check("ext_clr_extended", 32'(bus.extended), 32'h0);
    check("ext_rises",        32'(rises),        32'd4);
    wait_done_low("ext_done_fall");

    $display("[TB] bad parity and bad stop bit");
    send_frame(8'h1C, 1'b1, 1'b1);
    check("par_errs",  32'(err_count), 32'd1);
    check("par_tasta", 32'(bus.tasta), 32'h23);
    check("par_done",  32'(bus.done),  32'h0);
    send_frame(8'h29, 1'b0, 1'b0);
    check("stop_errs",  32'(err_count), 32'd2);
    check("stop_tasta", 32'(bus.tasta), 32'h23);
    check("stop_rises", 32'(rises),     32'd4);

    $display("[TB] partial frame timeout");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.ps2_data = 1'b1;
    waited = 0;
    for (int i = 0; i < 52000; i++) begin
      @(negedge clock);
      waited++;
      if (bus.frame_err === 1'b1) break;
    end
    repeat (3) @(negedge clock);
    check("to_errs",   32'(err_count), 32'd3);
    check("to_window", 32'(waited >= 49900 && waited <= 50100), 32'h1);
    send_frame(8'h4B, 1'b0, 1'b1);
    check("to_next_tasta", 32'(bus.tasta), 32'h4B);
    check("to_next_done",  32'(bus.done),  32'h1);
    check("to_next_errs",  32'(err_count), 32'd3);
    wait_done_low("to_done_fall");

    $display("[TB] back-to-back keys 1C then 23");
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (300) @(negedge clock);
    send_frame(8'h23, 1'b0, 1'b1);
    check("b2b_tasta",   32'(bus.tasta),    32'h23);
    check("b2b_done",    32'(bus.done),     32'h1);
    check("b2b_low_gap", 32'(last_low_len), 32'd1);
    check("b2b_rises",   32'(rises),        32'd7);
    wait_done_low("b2b_done_fall");
    check("b2b_hold_len", 32'(last_high_len), 32'd1024);

    $display("[TB] clock glitch");
    bus.ps2_data = 1'b1;
    bus.ps2_clk  = 1'b0;
    repeat (3) @(negedge clock);
    bus.ps2_clk  = 1'b1;
    repeat (40) @(negedge clock);
    check("glitch_errs",  32'(err_count), 32'd3);
    check("glitch_rises", 32'(rises),     32'd7);
    send_frame(8'h16, 1'b0, 1'b1);
    check("glitch_next_tasta", 32'(bus.tasta), 32'h16);

    $display("[TB] reset mid-frame");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("mid_rst_tasta", 32'(bus.tasta), 32'h00);
    check("mid_rst_done",  32'(bus.done),  32'h0);
    check("mid_rst_errs",  32'(err_count), 32'd3);
    send_frame(8'h1E, 1'b0, 1'b1);
    check("post_rst_tasta",    32'(bus.tasta),    32'h1E);
    check("post_rst_done",     32'(bus.done),     32'h1);
    check("post_rst_extended", 32'(bus.extended), 32'h0);
    check("post_rst_rises",    32'(rises),        32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
